dmem_port_arbiter: RTL and testbench

//  Shares the single-ported data memory between two requesters: port 0 = processor
//  ld/st path, port 1 = debug/loader port.

---
 rtl/dmem_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single-ported data memory between the processor ld/st path
//   (port 0) and the debug/loader port (port 1). Round-robin arbitration,
//   one outstanding access at a time. Each access takes RD_LAT cycles in the
//   memory and finishes with a one-cycle registered response pulse to the
//   port that won it.
//
// Ports
//   clk, reset               clock (rising edge), async active-high reset
//   reqN_valid/we/addr/wdata request from port N, held until reqN_ready
//   reqN_ready               accept strobe (combinational)
//   rspN_valid/rdata         response pulse and read data (0 for writes)
//   mem_en/we/addr/wdata     memory strobe and fields (all 0 when idle)
//   mem_rdata                memory read data, valid RD_LAT cycles after mem_en
//   grant_cnt0/1             saturating accept counters, present only when
//                            DMEM_ARB_STATS_EN is defined
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access outstanding; arbitrate and issue on any request
// WAIT  | access issued; count down the memory latency, then respond

module dmem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1
`endif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Counter holds RD_LAT-1 at most; keep it at least one bit wide.
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

  logic [0:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              owner_q, owner_d;
  logic              is_wr_q, is_wr_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;
  logic              grant1;
  logic [DATA_W-1:0] cap_data;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    owner_d      = owner_q;
    is_wr_d      = is_wr_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    grant1       = 1'b0;
    cap_data     = '0;

    case (state_q)
      ST_IDLE: begin
        // Ready/mem strobes are combinational from state, so hold them low
        // while reset is asserted rather than showing an IDLE accept.
        if (!reset && (req0_valid || req1_valid)) begin
          // On a tie the port that did not win last time gets the grant.
          grant1 = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
          mem_en = 1'b1;
          if (grant1) begin
            req1_ready = 1'b1;
            mem_we     = req1_we;
            mem_addr   = req1_addr;
            mem_wdata  = req1_wdata;
            is_wr_d    = req1_we;
          end else begin
            req0_ready = 1'b1;
            mem_we     = req0_we;
            mem_addr   = req0_addr;
            mem_wdata  = req0_wdata;
            is_wr_d    = req0_we;
          end
          last_grant_d = grant1;
          owner_d      = grant1;
          wait_cnt_d   = CNT_INIT;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == '0) begin
          cap_data = is_wr_q ? '0 : mem_rdata;
          if (owner_q) begin
            rsp1_valid_d = 1'b1;
            rsp1_rdata_d = cap_data;
          end else begin
            rsp0_valid_d = 1'b1;
            rsp0_rdata_d = cap_data;
          end
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      wait_cnt_q   <= '0;
      owner_q      <= 1'b0;
      is_wr_q      <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      owner_q      <= owner_d;
      is_wr_q      <= is_wr_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] grant_cnt0_q, grant_cnt0_d;
  logic [15:0] grant_cnt1_q, grant_cnt1_d;

  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    if (req0_ready && (grant_cnt0_q != 16'hFFFF)) grant_cnt0_d = grant_cnt0_q + 16'd1;
    if (req1_ready && (grant_cnt1_q != 16'hFFFF)) grant_cnt1_d = grant_cnt1_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: one instance with RD_LAT=1 and one
// with RD_LAT=3, each driving a small behavioural memory.

module tb_dmem_port_arbiter;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  // instance a: RD_LAT = 1
  logic        a_req0_valid, a_req0_we, a_req0_ready, a_rsp0_valid;
  logic [15:0] a_req0_addr, a_req0_wdata, a_rsp0_rdata;
  logic        a_req1_valid, a_req1_we, a_req1_ready, a_rsp1_valid;
  logic [15:0] a_req1_addr, a_req1_wdata, a_rsp1_rdata;
  logic        a_mem_en, a_mem_we;
  logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  // instance b: RD_LAT = 3
  logic        b_req0_valid, b_req0_we, b_req0_ready, b_rsp0_valid;
  logic [15:0] b_req0_addr, b_req0_wdata, b_rsp0_rdata;
  logic        b_req1_valid, b_req1_we, b_req1_ready, b_rsp1_valid;
  logic [15:0] b_req1_addr, b_req1_wdata, b_rsp1_rdata;
  logic        b_mem_en, b_mem_we;
  logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] a_gcnt0, a_gcnt1, b_gcnt0, b_gcnt1;
`endif

  dmem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1)) u_a (
    .clk(clk), .reset(reset),
    .req0_valid(a_req0_valid), .req0_we(a_req0_we), .req0_addr(a_req0_addr),
    .req0_wdata(a_req0_wdata), .req0_ready(a_req0_ready),
    .rsp0_valid(a_rsp0_valid), .rsp0_rdata(a_rsp0_rdata),
    .req1_valid(a_req1_valid), .req1_we(a_req1_we), .req1_addr(a_req1_addr),
    .req1_wdata(a_req1_wdata), .req1_ready(a_req1_ready),
    .rsp1_valid(a_rsp1_valid), .rsp1_rdata(a_rsp1_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .grant_cnt0(a_gcnt0), .grant_cnt1(a_gcnt1)
`endif
  );

  dmem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3)) u_b (
    .clk(clk), .reset(reset),
    .req0_valid(b_req0_valid), .req0_we(b_req0_we), .req0_addr(b_req0_addr),
    .req0_wdata(b_req0_wdata), .req0_ready(b_req0_ready),
    .rsp0_valid(b_rsp0_valid), .rsp0_rdata(b_rsp0_rdata),
    .req1_valid(b_req1_valid), .req1_we(b_req1_we), .req1_addr(b_req1_addr),
    .req1_wdata(b_req1_wdata), .req1_ready(b_req1_ready),
    .rsp1_valid(b_rsp1_valid), .rsp1_rdata(b_rsp1_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .grant_cnt0(b_gcnt0), .grant_cnt1(b_gcnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory a: one-cycle read latency; preset contents while reset is high
  logic [15:0] mem_a [0:255];
  always @(posedge clk) begin
    if (reset) begin
      mem_a[0]  <= 16'd420;
      mem_a[1]  <= 16'h0055;
      mem_a[16] <= 16'h0000;
    end else if (a_mem_en) begin
      if (a_mem_we) mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
      else          a_mem_rdata <= mem_a[a_mem_addr[7:0]];
    end
  end

  // memory b: three-cycle read latency; junk on the pipe when not reading
  logic [15:0] mem_b [0:255];
  logic [15:0] b_p1, b_p2;
  always @(posedge clk) begin
    if (reset) begin
      mem_b[32] <= 16'h1234;
      mem_b[33] <= 16'h5678;
    end
    b_p1        <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr[7:0]] : 16'hDEAD;
    b_p2        <= b_p1;
    b_mem_rdata <= b_p2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b1;
    {a_req0_valid, a_req0_we, a_req1_valid, a_req1_we} = '0;
    {b_req0_valid, b_req0_we, b_req1_valid, b_req1_we} = '0;
    a_req0_addr = '0; a_req0_wdata = '0; a_req1_addr = '0; a_req1_wdata = '0;
    b_req0_addr = '0; b_req0_wdata = '0; b_req1_addr = '0; b_req1_wdata = '0;
    a_mem_rdata = '0;
    b_p1 = '0; b_p2 = '0; b_mem_rdata = '0;

    tick();
    tick();
    #1;
    check("rst_ready0", a_req0_ready, 0);
    check("rst_mem_en", a_mem_en, 0);
    check("rst_rsp0_v", a_rsp0_valid, 0);
    check("rst_rsp0_d", a_rsp0_rdata, 0);
    check("rst_mem_addr", a_mem_addr, 0);
    reset = 1'b0;

    // single port-0 read, RD_LAT=1
    tick();
    a_req0_valid = 1'b1; a_req0_addr = 16'h0000;
    #1;
    check("t1_ready0", a_req0_ready, 1);
    check("t1_ready1", a_req1_ready, 0);
    check("t1_mem_en", a_mem_en, 1);
    check("t1_mem_we", a_mem_we, 0);
    tick();
    a_req0_valid = 1'b0;
    #1;
    check("t1_wait_ready0", a_req0_ready, 0);
    check("t1_wait_mem_en", a_mem_en, 0);
    check("t1_early_rsp", a_rsp0_valid, 0);
    tick();
    check("t1_rsp0_v", a_rsp0_valid, 1);
    check("t1_rsp0_d", a_rsp0_rdata, 16'd420);
    check("t1_rsp1_v", a_rsp1_valid, 0);

    // port-1 write then port-0 read-back
    tick();
    check("t3_rsp0_drop", a_rsp0_valid, 0);
    a_req1_valid = 1'b1; a_req1_we = 1'b1; a_req1_addr = 16'h0010; a_req1_wdata = 16'hBEEF;
    #1;
    check("t3_ready1", a_req1_ready, 1);
    check("t3_mem_we", a_mem_we, 1);
    check("t3_mem_addr", a_mem_addr, 16'h0010);
    check("t3_mem_wdata", a_mem_wdata, 16'hBEEF);
    tick();
    a_req1_valid = 1'b0; a_req1_we = 1'b0;
    #1;
    check("t3_idle_we", a_mem_we, 0);
    tick();
    check("t3_rsp1_v", a_rsp1_valid, 1);
    check("t3_rsp1_d", a_rsp1_rdata, 0);
    a_req0_valid = 1'b1; a_req0_addr = 16'h0010;
    #1;
    check("t3_ready0", a_req0_ready, 1);
    check("t3_rd_we", a_mem_we, 0);
    tick();
    a_req0_valid = 1'b0;
    tick();
    check("t3_rsp0_v", a_rsp0_valid, 1);
    check("t3_rsp0_d", a_rsp0_rdata, 16'hBEEF);

    // reset during WAIT
    tick();
    a_req1_valid = 1'b1; a_req1_addr = 16'h0000;
    #1;
    check("t5_ready1", a_req1_ready, 1);
    tick();
    a_req1_valid = 1'b0;
    #1;
    reset = 1'b1;
    a_req0_valid = 1'b1; a_req0_addr = 16'h0000;
    a_req1_valid = 1'b1; a_req1_addr = 16'h0001;
    #1;
    check("t5_rst_rsp0_d", a_rsp0_rdata, 0);
    check("t5_rst_ready0", a_req0_ready, 0);
    check("t5_rst_ready1", a_req1_ready, 0);
    check("t5_rst_mem_en", a_mem_en, 0);
    check("t5_rst_mem_addr", a_mem_addr, 0);
    tick();
    check("t5_no_rsp1", a_rsp1_valid, 0);
    reset = 1'b0;

    // both ports valid continuously: 0,1,0,1 every other cycle
    for (int c = 0; c < 9; c++) begin
      if (c > 0) tick();
      #1;
      check($sformatf("t2_ready0_c%0d", c), a_req0_ready, (c % 4) == 0);
      check($sformatf("t2_ready1_c%0d", c), a_req1_ready, (c % 4) == 2);
      check($sformatf("t2_rsp0_c%0d", c), a_rsp0_valid, (c % 4) == 2);
      check($sformatf("t2_rsp1_c%0d", c), a_rsp1_valid, ((c % 4) == 0) && (c > 0));
      if (c == 2) check("t2_rsp0_d", a_rsp0_rdata, 16'd420);
      if (c == 4) check("t2_rsp1_d", a_rsp1_rdata, 16'h0055);
    end
    a_req0_valid = 1'b0; a_req1_valid = 1'b0;

    // RD_LAT=3: port-0 read, port-1 raised one cycle later
    tick();
    b_req0_valid = 1'b1; b_req0_addr = 16'h0020;
    #1;
    check("t4_ready0", b_req0_ready, 1);
    tick();
    b_req0_valid = 1'b0;
    b_req1_valid = 1'b1; b_req1_addr = 16'h0021;
    for (int k = 1; k < 4; k++) begin
      if (k > 1) tick();
      #1;
      check($sformatf("t4_ready1_T%0d", k), b_req1_ready, 0);
      check($sformatf("t4_rsp0_T%0d", k), b_rsp0_valid, 0);
    end
    tick();
    check("t4_rsp0_v", b_rsp0_valid, 1);
    check("t4_rsp0_d", b_rsp0_rdata, 16'h1234);
    check("t4_ready1_T4", b_req1_ready, 1);
    tick();
    b_req1_valid = 1'b0;
    #1;
    check("t4_rsp0_drop", b_rsp0_valid, 0);
    tick();
    tick();
    check("t4_rsp1_early", b_rsp1_valid, 0);
    tick();
    check("t4_rsp1_v", b_rsp1_valid, 1);
    check("t4_rsp1_d", b_rsp1_rdata, 16'h5678);

`ifdef DMEM_ARB_STATS_EN
    reset = 1'b1;
    tick();
    check("t6_rst_cnt0", a_gcnt0, 0);
    reset = 1'b0;
    a_req0_valid = 1'b1; a_req0_addr = 16'h0000;
    a_req1_valid = 1'b1; a_req1_addr = 16'h0001;
    for (int c = 0; c < 16; c++) begin
      if (c == 12) a_req1_valid = 1'b0;
      tick();
    end
    a_req0_valid = 1'b0;
    tick();
    tick();
    check("t6_cnt0", a_gcnt0, 5);
    check("t6_cnt1", a_gcnt1, 3);
    force u_a.grant_cnt0_q = 16'hFFFF;
    #1;
    release u_a.grant_cnt0_q;
    a_req0_valid = 1'b1;
    tick();
    a_req0_valid = 1'b0;
    tick();
    tick();
    check("t6_sat", a_gcnt0, 16'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
